mac_accumulator: RTL and testbench
==================================

# mac_accumulator

Sequential multiply-accumulate controller that sits directly upstream and downstream of the combinational array multiplier. It accepts operand pairs over a valid/ready stream and drives them registered onto the multiplier's A/B inputs. It then sums the returned 2N-bit products into an accumulator and presents the dot-product result over a second valid/ready stream once a beat tagged `last` has been folded in.

## Interface
- `N`, 4, operand width; must match the attached multiplier's `n`.
- `ACC_W`, 16, accumulator/result width; must be ≥ 2·N (elaboration error otherwise).
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: operand pair present.
- `in_a` input N: multiplicand.
- `in_b` input N: multiplier.
- `in_last` input 1: final pair of the current dot product.
- `in_ready` output 1: registered; block accepts a pair this cycle.
- `mult_a` output N: registered operand to multiplier `A`.
- `mult_b` output N: registered operand to multiplier `B`.
- `mult_q` input 2·N: product from multiplier `Q`; combinational function of `mult_a`/`mult_b`.
- `out_valid` output 1: result held.
- `out_acc` output ACC_W: accumulated sum.
- `out_cnt` output 8: number of pairs accumulated, saturating at 255.
- `out_ovf` output 1: accumulator overflowed at least once during this result.
- `out_ready` input 1: consumer takes result.

## Operation
- FSM states:
  - ACC: accepting pairs.
  - DRAIN: last pair in flight.
  - DONE: result held.
- Reset values:
  - State ACC.
  - `in_ready`=0, `mult_a`=`mult_b`=0, `out_valid`=0, `out_acc`=0, `out_cnt`=0, `out_ovf`=0.
  - Internal product-valid flag `p_vld`=0.
- Accept = `in_valid && in_ready`. On accept, `mult_a`/`mult_b` load `in_a`/`in_b`, `p_vld`←1, and `p_last`←`in_last`. Otherwise `p_vld`←0 and `mult_a`/`mult_b` hold.
- Whenever `p_vld`=1:
  - acc ← acc + zero-extend(`mult_q`) to ACC_W.
  - Carry out of bit ACC_W−1 sets sticky ovf; acc wraps modulo 2^ACC_W.
  - cnt ← cnt+1, saturating at 255.
- Transitions:
  - ACC → DRAIN on accept with `in_last`=1.
  - DRAIN → DONE unconditionally next cycle; the final product is added in that edge.
  - DONE → ACC on `out_ready`=1. The same edge clears acc, cnt, and ovf to 0.
- `in_ready` register ← 1 iff next state is ACC and `reset`=0.
- `out_valid` = (state==DONE), registered. `out_acc`, `out_cnt`, and `out_ovf` reflect internal acc/cnt/ovf and are stable throughout DONE.
- Unsigned arithmetic only. A product of 0 still increments cnt.
- `reset` asserted in any state, including mid-DRAIN with a product in flight, discards everything; the in-flight product is not added.

## Timing
- Throughput: one pair per cycle while in ACC.
- Latency: last pair accepted at edge t → `out_valid`=1 after edge t+2.
- `in_ready` falls after edge t and stays 0 through DRAIN/DONE. It rises after the edge at which `out_ready` is sampled high in DONE. There is no bubble-free overlap between results: min 1 idle cycle.
- `out_valid` with `out_ready`=0 holds indefinitely; outputs must not change.
- `in_valid` without `in_ready` is ignored; the upstream block must hold its data (standard valid/ready, no combinational ready→valid path).
- `mult_q` is sampled one cycle after the operands were registered. The multiplier path must close in one cycle.
- First cycle after `reset` falls: `in_ready` is still 0; it becomes 1 after the next edge.

## Configuration
- `MAC_SATURATE_EN` defined:
  - On overflow, acc clamps to 2^ACC_W−1 and stays there for the rest of the dot product.
  - `out_ovf` is still set.
- Not defined: modulo wrap as in Operation.

## Test plan
- N=4, ACC_W=16, reset then pairs (3,5),(15,15),(7,2 last) → `out_acc`=254, `out_cnt`=3, `out_ovf`=0, `out_valid` exactly 2 cycles after the last accept.
- Single pair (0,9 last) → `out_acc`=0, `out_cnt`=1.
- Hold `out_ready`=0 for 10 cycles in DONE while driving `in_valid`=1 → outputs constant, `in_ready`=0, no beats consumed. Then `out_ready`=1 → next result starts from 0.
- ACC_W=8, five pairs (15,15) last on 5th (sum 1125):
  - Without `MAC_SATURATE_EN` → `out_acc`=101, `out_ovf`=1.
  - With it → `out_acc`=255, `out_ovf`=1.
- Assert `reset` the cycle after a last accept (DRAIN) → `out_valid` never rises, all outputs 0, then a fresh (2,3 last) → `out_acc`=6.
- Toggle `in_valid` randomly across 300 pairs of (1,1) with the last on the 300th → `out_acc`=300, `out_cnt`=255.

Source files
------------

// File: rtl/mac_accumulator.sv
// mac_accumulator: multiply-accumulate controller wrapped around an external
// combinational N x N multiplier. Operand pairs arrive on a valid/ready stream,
// are registered onto the multiplier inputs, and the returned products are
// summed. The dot product is presented on a second valid/ready stream once the
// beat tagged last has been folded in.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   in_valid/in_ready   operand stream handshake (in_ready is registered)
//   in_a, in_b, in_last operand pair and end-of-dot-product tag
//   mult_a, mult_b      registered operands to the multiplier
//   mult_q              multiplier product (2*N bits, combinational from mult_a/b)
//   out_valid/out_ready result stream handshake
//   out_acc             accumulated sum (ACC_W bits)
//   out_cnt             pairs accumulated, saturating at 255
//   out_ovf             sticky accumulator overflow for this result
//
// Build option: define MAC_SATURATE_EN to clamp the accumulator at all-ones on
// overflow instead of wrapping modulo 2^ACC_W.
module mac_accumulator #(
  parameter int unsigned N     = 4,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_last,
  output logic             in_ready,
  output logic [N-1:0]     mult_a,
  output logic [N-1:0]     mult_b,
  input  logic [2*N-1:0]   mult_q,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_acc,
  output logic [7:0]       out_cnt,
  output logic             out_ovf,
  input  logic             out_ready
);

  if (ACC_W < 2 * N) begin : g_bad_width
    $error("mac_accumulator: ACC_W must be at least 2*N");
  end

  typedef enum logic [1:0] {StAcc, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic             p_vld;
  logic             accept;
  logic             take;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_d;

  always_comb begin
    accept  = in_valid && in_ready;
    take    = out_valid && out_ready;
    state_d = state_q;
    unique case (state_q)
      StAcc:   if (accept && in_last) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  if (take) state_d = StAcc;
      default: state_d = StAcc;
    endcase
  end

  // One extra bit catches the carry out of the accumulator.
  always_comb begin
    sum   = {1'b0, out_acc} + (ACC_W + 1)'(mult_q);
    carry = sum[ACC_W];
`ifdef MAC_SATURATE_EN
    // Once overflowed, stay pinned at all-ones for the rest of the dot product.
    acc_d = (carry || out_ovf) ? '1 : sum[ACC_W-1:0];
`else
    acc_d = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StAcc;
      in_ready  <= 1'b0;
      mult_a    <= '0;
      mult_b    <= '0;
      p_vld     <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d == StAcc);
      // out_valid trails entry into DONE by one cycle and drops on the
      // handshake edge, so it never stays high after the result is taken.
      out_valid <= (state_q == StDone) && (state_d == StDone);
      p_vld     <= accept;
      if (accept) begin
        mult_a <= in_a;
        mult_b <= in_b;
      end
      if (take) begin
        out_acc <= '0;
        out_cnt <= '0;
        out_ovf <= 1'b0;
      end else if (p_vld) begin
        out_acc <= acc_d;
        out_ovf <= out_ovf | carry;
        if (out_cnt != 8'hFF) out_cnt <= out_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
module tb_mac_accumulator;

  typedef struct {
    logic [15:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  logic        clk = 0;
  logic        reset = 1;

  // Main DUT, ACC_W = 16.
  logic        in_valid = 0, in_last = 0, in_ready;
  logic [3:0]  in_a = 0, in_b = 0, mult_a, mult_b;
  logic [7:0]  mult_q;
  logic        out_valid, out_ovf, out_ready = 1;
  logic [15:0] out_acc;
  logic [7:0]  out_cnt;

  // Narrow DUT, ACC_W = 8, for overflow behaviour.
  logic        in8_valid = 0, in8_last = 0, in8_ready;
  logic [3:0]  in8_a = 0, in8_b = 0, mult8_a, mult8_b;
  logic [7:0]  mult8_q;
  logic        out8_valid, out8_ovf, out8_ready = 1;
  logic [7:0]  out8_acc;
  logic [7:0]  out8_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   done8 = 0;
  exp_t exp_q[$];
  int   rise_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-ins for the combinational multipliers.
  assign mult_q  = 8'(mult_a) * 8'(mult_b);
  assign mult8_q = 8'(mult8_a) * 8'(mult8_b);

  mac_accumulator #(.N(4), .ACC_W(16)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_q    (mult_q),
    .out_valid (out_valid),
    .out_acc   (out_acc),
    .out_cnt   (out_cnt),
    .out_ovf   (out_ovf),
    .out_ready (out_ready)
  );

  mac_accumulator #(.N(4), .ACC_W(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in8_valid),
    .in_a      (in8_a),
    .in_b      (in8_b),
    .in_last   (in8_last),
    .in_ready  (in8_ready),
    .mult_a    (mult8_a),
    .mult_b    (mult8_b),
    .mult_q    (mult8_q),
    .out_valid (out8_valid),
    .out_acc   (out8_acc),
    .out_cnt   (out8_cnt),
    .out_ovf   (out8_ovf),
    .out_ready (out8_ready)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [15:0] acc, input logic [7:0] cnt, input logic ovf);
    exp_t e;
    e.acc = acc;
    e.cnt = cnt;
    e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last,
                      input bit track);
    bit ok = 0;
    in_valid = 1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else if (last && track) rise_q.push_back(cyc + 3);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("result_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor for the main DUT: latency on each rise, result contents on every
  // valid cycle (so holding must keep them constant), pop on handshake.
  initial begin
    bit prev_valid = 0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_valid) begin
        if (rise_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("latency_cycle", cyc, rise_q.pop_front());
      end
      prev_valid = out_valid;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("result_without_expectation", 1, 0);
        end else begin
          chk("out_acc", out_acc, exp_q[0].acc);
          chk("out_cnt", out_cnt, exp_q[0].cnt);
          chk("out_ovf", out_ovf, exp_q[0].ovf);
          chk("in_ready_in_done", in_ready, 0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Narrow DUT: five (15,15) pairs, sum 1125.
  initial begin
    logic [7:0] want8;
`ifdef MAC_SATURATE_EN
    want8 = 8'd255;
`else
    want8 = 8'd101;
`endif
    wait (!reset);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      bit ok = 0;
      in8_valid = 1;
      in8_a     = 4'd15;
      in8_b     = 4'd15;
      in8_last  = (i == 4);
      for (int j = 0; j < 50; j++) begin
        @(negedge clk);
        if (in8_ready) begin
          ok = 1;
          break;
        end
      end
      if (!ok) chk("acc8_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    in8_valid = 0;
    in8_last  = 0;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (out8_valid && out8_ready && !done8) begin
        chk("acc8_out_acc", out8_acc, want8_fn());
        chk("acc8_out_cnt", out8_cnt, 5);
        chk("acc8_out_ovf", out8_ovf, 1);
        done8 = 1;
      end
    end
  end

  function automatic logic [7:0] want8_fn();
`ifdef MAC_SATURATE_EN
    return 8'd255;
`else
    return 8'd101;
`endif
  endfunction

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_mult_a", mult_a, 0);
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("first_cycle_in_ready", in_ready, 0);
    @(negedge clk);
    chk("second_cycle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // 15 + 225 + 14 = 254
    push_exp(16'd254, 8'd3, 1'b0);
    send(4'd3, 4'd5, 1'b0, 1'b1);
    send(4'd15, 4'd15, 1'b0, 1'b1);
    send(4'd7, 4'd2, 1'b1, 1'b1);
    wait_drain();

    // Zero product still counts; then hold the result with in_valid pending.
    out_ready = 0;
    push_exp(16'd0, 8'd1, 1'b0);
    send(4'd0, 4'd9, 1'b1, 1'b1);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("hold_valid_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1;
    in_a     = 4'd4;
    in_b     = 4'd4;
    in_last  = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    push_exp(16'd16, 8'd1, 1'b0);
    send(4'd4, 4'd4, 1'b1, 1'b1);
    wait_drain();

    // Reset while the last product is in flight.
    send(4'd5, 4'd5, 1'b1, 1'b0);
    reset = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain_rst_out_valid", out_valid, 0);
    chk("drain_rst_out_acc", out_acc, 0);
    chk("drain_rst_out_cnt", out_cnt, 0);
    chk("drain_rst_out_ovf", out_ovf, 0);
    chk("drain_rst_in_ready", in_ready, 0);
    chk("drain_rst_mult_b", mult_b, 0);
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 0);
    repeat (5) @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    push_exp(16'd6, 8'd1, 1'b0);
    send(4'd2, 4'd3, 1'b1, 1'b1);
    wait_drain();

    // 300 unit products with random gaps; count saturates.
    push_exp(16'd300, 8'd255, 1'b0);
    for (int i = 1; i <= 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(4'd1, 4'd1, (i == 300), 1'b1);
    end
    wait_drain();

    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (done8) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("acc8_result_seen", ok, 1);
    chk("pending_rises", rise_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
